// File: rtl/jtoutrun_pal_dma.sv
// Palette DMA: copies colour words from a source RAM into palette RAM during vblank,
// fading each 5-bit channel on the way and yielding to CPU palette accesses.
module jtoutrun_pal_dma #(
    parameter int AW  = 11,
    parameter int SAW = 12
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           LVBL,
    input  logic           start,
    input  logic [SAW-1:0] src_base,
    input  logic [AW-1:0]  dst_base,
    input  logic [AW-1:0]  len,
    input  logic [4:0]     level,
    output logic           src_cs,
    output logic [SAW-1:0] src_addr,
    input  logic [15:0]    src_data,
    input  logic           src_ok,
    input  logic           cpu_pal_cs,
    output logic [12:0]    pal_addr,
    output logic [15:0]    pal_dout,
    output logic [1:0]     pal_we,
    output logic           busy,
    output logic           done
);

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_WAITVB = 3'd1;
    localparam logic [2:0] ST_READ   = 3'd2;
    localparam logic [2:0] ST_WRITE  = 3'd3;
    localparam logic [2:0] ST_DONE   = 3'd4;

    function automatic logic [4:0] fade_ch(input logic [4:0] c, input logic [4:0] lvl);
        logic [9:0] prod;
        prod = 10'(c) * 10'(lvl);
        return 5'(prod >> 4);
    endfunction

    // Channel = {nibble, lsb}; lsb bits live in [14:12], shadow bit 15 passes through.
    function automatic logic [15:0] fade_word(input logic [15:0] w, input logic [4:0] lvl);
        logic [4:0] r;
        logic [4:0] g;
        logic [4:0] b;
        r = fade_ch({w[3:0],  w[12]}, lvl);
        g = fade_ch({w[7:4],  w[13]}, lvl);
        b = fade_ch({w[11:8], w[14]}, lvl);
        return {w[15], b[0], g[0], r[0], b[4:1], g[4:1], r[4:1]};
    endfunction

    logic [2:0]     state_q,    state_d;
    logic [SAW-1:0] src_base_q, src_base_d;
    logic [AW-1:0]  dst_base_q, dst_base_d;
    logic [AW-1:0]  len_q,      len_d;
    logic [4:0]     lvl_q,      lvl_d;
    logic [AW-1:0]  cnt_q,      cnt_d;
    logic           src_cs_q,   src_cs_d;
    logic [SAW-1:0] src_addr_q, src_addr_d;
    logic [AW-1:0]  pal_idx_q,  pal_idx_d;
    logic [15:0]    pal_dout_q, pal_dout_d;
    logic           busy_q,     busy_d;
    logic           done_q,     done_d;
    logic [AW-1:0]  cnt_nxt_s;

    assign cnt_nxt_s = cnt_q + AW'(1);

    // Transfer sequencing and next-state computation
    always_comb begin
        state_d    = state_q;
        src_base_d = src_base_q;
        dst_base_d = dst_base_q;
        len_d      = len_q;
        lvl_d      = lvl_q;
        cnt_d      = cnt_q;
        src_cs_d   = src_cs_q;
        src_addr_d = src_addr_q;
        pal_idx_d  = pal_idx_q;
        pal_dout_d = pal_dout_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    src_base_d = src_base;
                    dst_base_d = dst_base;
                    len_d      = len;
                    lvl_d      = (level > 5'd16) ? 5'd16 : level;
                    cnt_d      = '0;
                    busy_d     = 1'b1;
                    state_d    = ST_WAITVB;
                end else begin
                    state_d    = ST_IDLE;
                end
            end
            ST_WAITVB: begin
                if (!LVBL) begin
                    state_d    = ST_READ;
                    src_cs_d   = 1'b1;
                    src_addr_d = src_base_q + SAW'(cnt_q);
                end else begin
                    state_d    = ST_WAITVB;
                end
            end
            ST_READ: begin
                if (src_ok) begin
                    src_cs_d   = 1'b0;
                    pal_dout_d = fade_word(src_data, lvl_q);
                    pal_idx_d  = dst_base_q + cnt_q;
                    state_d    = ST_WRITE;
                end else begin
                    src_cs_d   = 1'b1;
                end
            end
            ST_WRITE: begin
                // Vblank is only re-checked here, so a word already in flight always completes
                if (!cpu_pal_cs) begin
                    if (cnt_q == len_q) begin
                        done_d  = 1'b1;
                        state_d = ST_DONE;
                    end else begin
                        cnt_d = cnt_nxt_s;
                        if (!LVBL) begin
                            state_d    = ST_READ;
                            src_cs_d   = 1'b1;
                            src_addr_d = src_base_q + SAW'(cnt_nxt_s);
                        end else begin
                            state_d    = ST_WAITVB;
                        end
                    end
                end else begin
                    state_d = ST_WRITE;
                end
            end
            ST_DONE: begin
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
            default: begin
                state_d  = ST_IDLE;
                src_cs_d = 1'b0;
                busy_d   = 1'b0;
            end
        endcase
    end

    // State and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            src_base_q <= '0;
            dst_base_q <= '0;
            len_q      <= '0;
            lvl_q      <= 5'd0;
            cnt_q      <= '0;
            src_cs_q   <= 1'b0;
            src_addr_q <= '0;
            pal_idx_q  <= '0;
            pal_dout_q <= 16'h0000;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            src_base_q <= src_base_d;
            dst_base_q <= dst_base_d;
            len_q      <= len_d;
            lvl_q      <= lvl_d;
            cnt_q      <= cnt_d;
            src_cs_q   <= src_cs_d;
            src_addr_q <= src_addr_d;
            pal_idx_q  <= pal_idx_d;
            pal_dout_q <= pal_dout_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    // Write enable reacts to the CPU in the same cycle so the CPU never loses a slot
    assign pal_we   = (state_q == ST_WRITE && !cpu_pal_cs) ? 2'b11 : 2'b00;
    assign pal_addr = {{(13-AW){1'b0}}, pal_idx_q};
    assign pal_dout = pal_dout_q;
    assign src_cs   = src_cs_q;
    assign src_addr = src_addr_q;
    assign busy     = busy_q;
    assign done     = done_q;

endmodule

// File: tb/tb_jtoutrun_pal_dma.sv
// Directed bench for jtoutrun_pal_dma: source RAM responder, palette write logger,
// and a linear sequence of hand-computed checks.
module tb_jtoutrun_pal_dma;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        LVBL = 1'b1;
    logic        start = 1'b0;
    logic [11:0] src_base = 12'h000;
    logic [10:0] dst_base = 11'h000;
    logic [10:0] len = 11'h000;
    logic [4:0]  level = 5'd0;
    logic        src_cs;
    logic [11:0] src_addr;
    logic [15:0] src_data = 16'h0000;
    logic        src_ok = 1'b0;
    logic        cpu_pal_cs = 1'b0;
    logic [12:0] pal_addr;
    logic [15:0] pal_dout;
    logic [1:0]  pal_we;
    logic        busy;
    logic        done;

    int checks = 0;
    int failures = 0;

    logic [15:0] src_mem [0:4095];
    logic [15:0] pal_mem [0:2047];
    logic [12:0] wr_addr_log [0:255];
    int          wr_cyc_log [0:255];
    int          wr_count = 0;
    int          done_cnt = 0;
    int          viol_cnt = 0;
    int          cyc = 0;
    logic        seen_cs = 1'b0;
    logic [36:0] fv [0:6];

    jtoutrun_pal_dma #(.AW(11), .SAW(12)) dut (
        .clk(clk), .rst(rst), .LVBL(LVBL), .start(start),
        .src_base(src_base), .dst_base(dst_base), .len(len), .level(level),
        .src_cs(src_cs), .src_addr(src_addr), .src_data(src_data), .src_ok(src_ok),
        .cpu_pal_cs(cpu_pal_cs), .pal_addr(pal_addr), .pal_dout(pal_dout),
        .pal_we(pal_we), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    // Source RAM: acknowledges one cycle after the request is first seen
    always @(negedge clk) begin
        src_ok = src_cs & seen_cs;
        if (src_ok) src_data = src_mem[src_addr];
        seen_cs = src_cs & ~src_ok;
    end

    // Palette logger: records every write and done pulse, flags illegal enables
    always @(posedge clk) begin
        cyc++;
        if (pal_we == 2'b11) begin
            pal_mem[pal_addr[10:0]] = pal_dout;
            wr_addr_log[wr_count % 256] = pal_addr;
            wr_cyc_log[wr_count % 256] = cyc;
            wr_count++;
            if (cpu_pal_cs) viol_cnt++;
        end else if (pal_we != 2'b00) begin
            viol_cnt++;
        end
        if (done) done_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic start_xfer(input logic [11:0] sb, input logic [10:0] db,
                              input logic [10:0] ln, input logic [4:0] lv);
        src_base = sb;
        dst_base = db;
        len      = ln;
        level    = lv;
        start    = 1'b1;
        step(1);
        start    = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int budget);
        int d0;
        d0 = done_cnt;
        for (int i = 0; i < budget; i++) begin
            if (done_cnt != d0) break;
            step(1);
        end
        chk(tag, done_cnt - d0, 1);
    endtask

    initial begin
        int n0;
        int d0;
        logic found;

        for (int i = 0; i < 4096; i++) src_mem[i] = 16'h0000;
        for (int i = 0; i < 2048; i++) pal_mem[i] = 16'h0000;
        src_mem[12'h100] = 16'h1234;
        src_mem[12'h101] = 16'hFEDC;
        src_mem[12'h102] = 16'h8001;
        src_mem[12'h103] = 16'h7FFF;
        src_mem[12'h180] = 16'hC3A5;
        src_mem[12'h181] = 16'h0F0F;
        for (int i = 0; i < 8; i++) src_mem[12'h300 + i] = 16'hA000 + 16'(i) * 16'h0111;
        for (int i = 0; i < 4; i++) src_mem[12'h400 + i] = 16'h0C00 + 16'(i);
        for (int i = 0; i < 8; i++) src_mem[12'h500 + i] = 16'h5A5A ^ 16'(i + 1);
        src_mem[12'h600] = 16'h6001;
        src_mem[12'h601] = 16'h6002;
        fv[0] = {16'h7FFF, 5'd8,  16'h7777};
        fv[1] = {16'h8000, 5'd0,  16'h8000};
        fv[2] = {16'hFFFF, 5'd0,  16'h8000};
        fv[3] = {16'h7FFF, 5'd31, 16'h7FFF};
        fv[4] = {16'h0008, 5'd4,  16'h0002};
        fv[5] = {16'h1000, 5'd15, 16'h0000};
        fv[6] = {16'h20F0, 5'd12, 16'h20B0};

        // Reset state
        step(3);
        chk("rst_src_cs", {31'd0, src_cs}, 32'd0);
        chk("rst_src_addr", {20'd0, src_addr}, 32'd0);
        chk("rst_pal_addr", {19'd0, pal_addr}, 32'd0);
        chk("rst_pal_dout", {16'd0, pal_dout}, 32'd0);
        chk("rst_pal_we", {30'd0, pal_we}, 32'd0);
        chk("rst_busy_done", {30'd0, busy, done}, 32'd0);
        rst = 1'b0;
        step(2);

        // 1: straight copy at full level
        LVBL = 1'b0;
        n0 = wr_count;
        start_xfer(12'h100, 11'h000, 11'd3, 5'd16);
        chk("t1_busy", {31'd0, busy}, 32'd1);
        wait_done("t1_done", 200);
        chk("t1_busy_low", {31'd0, busy}, 32'd0);
        chk("t1_writes", wr_count - n0, 32'd4);
        for (int i = 0; i < 4; i++) begin
            chk("t1_addr", {19'd0, wr_addr_log[(n0 + i) % 256]}, 32'(i));
            chk("t1_data", {16'd0, pal_mem[i]}, {16'd0, src_mem[12'h100 + i]});
        end
        chk("t1_rate", wr_cyc_log[(n0 + 3) % 256] - wr_cyc_log[n0 % 256], 32'd9);

        // 2: fade vectors, single-word transfers
        for (int i = 0; i < 7; i++) begin
            src_mem[12'h200] = fv[i][36:21];
            n0 = wr_count;
            start_xfer(12'h200, 11'h010, 11'd0, fv[i][20:16]);
            wait_done("t2_done", 100);
            chk("t2_writes", wr_count - n0, 32'd1);
            chk("t2_fade", {16'd0, pal_mem[11'h010]}, {16'd0, fv[i][15:0]});
        end

        // 3: CPU holds the palette for 5 cycles while a write is pending
        n0 = wr_count;
        start_xfer(12'h180, 11'h020, 11'd1, 5'd16);
        found = 1'b0;
        for (int i = 0; i < 50; i++) begin
            if (src_ok) begin
                found = 1'b1;
                break;
            end
            step(1);
        end
        chk("t3_ack_seen", {31'd0, found}, 32'd1);
        cpu_pal_cs = 1'b1;
        for (int k = 0; k < 5; k++) begin
            step(1);
            chk("t3_stall_we", {30'd0, pal_we}, 32'd0);
        end
        chk("t3_no_write", wr_count - n0, 32'd0);
        cpu_pal_cs = 1'b0;
        #1;
        chk("t3_release_we", {30'd0, pal_we}, 32'd3);
        wait_done("t3_done", 100);
        chk("t3_writes", wr_count - n0, 32'd2);
        chk("t3_data0", {16'd0, pal_mem[11'h020]}, 32'h0000C3A5);
        chk("t3_data1", {16'd0, pal_mem[11'h021]}, 32'h00000F0F);

        // 4: active display starts during word 1 of 8
        n0 = wr_count;
        start_xfer(12'h300, 11'h040, 11'd7, 5'd16);
        found = 1'b0;
        for (int i = 0; i < 100; i++) begin
            step(1);
            if (wr_count - n0 == 1 && pal_we == 2'b11) begin
                found = 1'b1;
                break;
            end
        end
        chk("t4_word1_seen", {31'd0, found}, 32'd1);
        LVBL = 1'b1;
        step(10);
        chk("t4_paused_writes", wr_count - n0, 32'd2);
        chk("t4_paused_cs", {31'd0, src_cs}, 32'd0);
        chk("t4_paused_busy", {31'd0, busy}, 32'd1);
        LVBL = 1'b0;
        wait_done("t4_done", 200);
        chk("t4_writes", wr_count - n0, 32'd8);
        for (int i = 0; i < 8; i++)
            chk("t4_data", {16'd0, pal_mem[11'h040 + i]}, {16'd0, 16'hA000 + 16'(i) * 16'h0111});

        // 5: destination wraps; a second start while busy is ignored
        n0 = wr_count;
        d0 = done_cnt;
        start_xfer(12'h400, 11'h7FE, 11'd3, 5'd16);
        step(2);
        start_xfer(12'h000, 11'h100, 11'd7, 5'd16);
        wait_done("t5_done", 200);
        step(20);
        chk("t5_writes", wr_count - n0, 32'd4);
        chk("t5_done_once", done_cnt - d0, 32'd1);
        chk("t5_addr0", {19'd0, wr_addr_log[n0 % 256]}, 32'h7FE);
        chk("t5_addr1", {19'd0, wr_addr_log[(n0 + 1) % 256]}, 32'h7FF);
        chk("t5_addr2", {19'd0, wr_addr_log[(n0 + 2) % 256]}, 32'h000);
        chk("t5_addr3", {19'd0, wr_addr_log[(n0 + 3) % 256]}, 32'h001);
        chk("t5_data_wrap", {16'd0, pal_mem[11'h001]}, 32'h00000C03);

        // 6: reset during a read aborts, then a fresh transfer runs cleanly
        n0 = wr_count;
        start_xfer(12'h500, 11'h050, 11'd7, 5'd16);
        found = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (wr_count - n0 >= 1 && src_cs) begin
                found = 1'b1;
                break;
            end
            step(1);
        end
        chk("t6_in_read", {31'd0, found}, 32'd1);
        rst = 1'b1;
        #1;
        chk("t6_rst_cs", {31'd0, src_cs}, 32'd0);
        chk("t6_rst_busy", {31'd0, busy}, 32'd0);
        chk("t6_rst_dout", {16'd0, pal_dout}, 32'd0);
        chk("t6_rst_addr", {19'd0, pal_addr}, 32'd0);
        chk("t6_rst_we", {30'd0, pal_we}, 32'd0);
        n0 = wr_count;
        d0 = done_cnt;
        step(3);
        rst = 1'b0;
        step(20);
        chk("t6_no_writes", wr_count - n0, 32'd0);
        chk("t6_no_done", done_cnt - d0, 32'd0);
        start_xfer(12'h600, 11'h060, 11'd1, 5'd16);
        wait_done("t6_done", 100);
        chk("t6_writes", wr_count - n0, 32'd2);
        chk("t6_data0", {16'd0, pal_mem[11'h060]}, 32'h00006001);
        chk("t6_data1", {16'd0, pal_mem[11'h061]}, 32'h00006002);

        chk("illegal_we", viol_cnt, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
